light_show_ctrl: RTL

LIGHT_SHOW_CTRL -- requirements
Module: light_show_ctrl

---
 rtl/light_pkg.sv | 40 ++++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/light_show_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/light_pkg.sv
// Shared types, widths and helpers for the light show controller.
// LIGHT_SHOW_BLINK_EN adds BLINK to the mode rotation.
package light_pkg;

   localparam int unsigned LEDS_W = 8;

   localparam logic [LEDS_W-1:0] START_DOT   = 8'h01;
   localparam logic [LEDS_W-1:0] START_BLINK = 8'hFF;

   typedef enum logic [1:0] {
      BOUNCE = 2'd0,
      ROT_L  = 2'd1,
      ROT_R  = 2'd2,
      BLINK  = 2'd3
   } mode_e;

   function automatic mode_e next_mode(input mode_e m);
      mode_e n;
      case (m)
         BOUNCE:  n = ROT_L;
         ROT_L:   n = ROT_R;
`ifdef LIGHT_SHOW_BLINK_EN
         ROT_R:   n = BLINK;
`else
         ROT_R:   n = BOUNCE;
`endif
         default: n = BOUNCE;
      endcase
      return n;
   endfunction

   function automatic logic [LEDS_W-1:0] start_value(input mode_e m);
      return (m == BLINK) ? START_BLINK : START_DOT;
   endfunction

   function automatic logic is_onehot(input logic [LEDS_W-1:0] v);
      return (v != '0) && ((v & (v - 8'd1)) == '0);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler producing one tick every (BASE_DIV >> speed) enabled cycles.
// Counter holds while disabled; clr restarts the period.
module tick_prescaler #(
   parameter int unsigned       DIV_W    = 24,
   parameter logic [DIV_W-1:0]  BASE_DIV = 24'd1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       clr,
   input  logic [1:0] speed,
   output logic       tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] period_m1;

   // >= rather than == so a speed increase past the current count fires at once
   always_comb begin
      period_m1 = (BASE_DIV >> speed) - DIV_W'(1);
      tick      = en && (cnt_q >= period_m1);
      cnt_d     = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/light_show_ctrl.sv
// Light show controller: run/pause, mode FSM and registered LED pattern.
// LIGHT_SHOW_BLINK_EN enables the BLINK mode (see light_pkg).
module light_show_ctrl
   import light_pkg::*;
#(
   parameter int unsigned       DIV_W    = 24,
   parameter logic [DIV_W-1:0]  BASE_DIV = 24'd1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_run,
   input  logic              btn_mode,
   input  logic [1:0]        speed,
   output logic [LEDS_W-1:0] leds,
   output logic [1:0]        mode,
   output logic              running
);

   mode_e             mode_q, mode_d, mode_nxt;
   logic [LEDS_W-1:0] leds_q, leds_d;
   logic              dir_q, dir_d;       // 0 = moving left, 1 = moving right
   logic              running_q, running_d;
   logic              tick;

   tick_prescaler #(
      .DIV_W    (DIV_W),
      .BASE_DIV (BASE_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .en    (running_q),
      .clr   (btn_mode),
      .speed (speed),
      .tick  (tick)
   );

   always_comb begin
      mode_nxt  = next_mode(mode_q);
      mode_d    = mode_q;
      leds_d    = leds_q;
      dir_d     = dir_q;
      running_d = running_q ^ btn_run;

      // A mode change swallows any coincident tick
      if (btn_mode) begin
         mode_d = mode_nxt;
         leds_d = start_value(mode_nxt);
         dir_d  = 1'b0;
      end else if (tick) begin
         unique case (mode_q)
            BOUNCE: begin
               if (!is_onehot(leds_q)) begin
                  leds_d = START_DOT;
                  dir_d  = 1'b0;
               end else if (!dir_q) begin
                  if (leds_q == 8'h80) begin
                     leds_d = 8'h40;
                     dir_d  = 1'b1;
                  end else begin
                     leds_d = leds_q << 1;
                  end
               end else begin
                  if (leds_q == 8'h01) begin
                     leds_d = 8'h02;
                     dir_d  = 1'b0;
                  end else begin
                     leds_d = leds_q >> 1;
                  end
               end
            end
            ROT_L:  leds_d = {leds_q[LEDS_W-2:0], leds_q[LEDS_W-1]};
            ROT_R:  leds_d = {leds_q[0], leds_q[LEDS_W-1:1]};
            BLINK:  leds_d = ~leds_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q    <= BOUNCE;
         leds_q    <= START_DOT;
         dir_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         leds_q    <= leds_d;
         dir_q     <= dir_d;
         running_q <= running_d;
      end
   end

   assign leds    = leds_q;
   assign mode    = mode_q;
   assign running = running_q;

endmodule
